// File: rtl/alarm_annunciator.sv
// alarm_annunciator: registered output stage of the car alarm.
// Produces a blinking armed LED, a pulsed horn with bounded run time and a
// lockout flag, all paced by the divider tick and free of decode glitches.
module alarm_annunciator #(
  parameter int LED_ON_TICKS  = 1,
  parameter int LED_OFF_TICKS = 3,
  parameter int SIREN_TICKS   = 30
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic status_ind,
  input  logic siren_req,
  output logic led,
  output logic horn,
  output logic siren_lockout
);

  localparam int CW   = (SIREN_TICKS > 1) ? $clog2(SIREN_TICKS) : 1;
  localparam int BMAX = (LED_ON_TICKS > LED_OFF_TICKS) ? LED_ON_TICKS : LED_OFF_TICKS;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] SOUND_LAST = CW'(SIREN_TICKS - 1);
  localparam logic [BW-1:0] ON_LAST    = BW'(LED_ON_TICKS - 1);
  localparam logic [BW-1:0] OFF_LAST   = BW'(LED_OFF_TICKS - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SOUND   = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] sound_cnt_q, sound_cnt_d;
  logic          horn_q, horn_d;
  logic          lockout_q, lockout_d;
  logic          led_q, led_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;
  logic          status_prev_q, status_prev_d;

  assign led           = led_q;
  assign horn          = horn_q;
  assign siren_lockout = lockout_q;

  // Siren FSM: horn toggles per tick in SOUND, times out into LOCKOUT.
  // A dropped request always wins over the final tick.
  always_comb begin
    state_d     = state_q;
    sound_cnt_d = sound_cnt_q;
    horn_d      = horn_q;
    case (state_q)
      ST_IDLE: begin
        horn_d      = 1'b0;
        sound_cnt_d = '0;
        if (siren_req) begin
          state_d = ST_SOUND;
          horn_d  = 1'b1;
        end
      end
      ST_SOUND: begin
        if (!siren_req) begin
          state_d     = ST_IDLE;
          horn_d      = 1'b0;
          sound_cnt_d = '0;
        end else if (tick) begin
          if (sound_cnt_q == SOUND_LAST) begin
            state_d = ST_LOCKOUT;
            horn_d  = 1'b0;
          end else begin
            // Increment only below the last value, so the counter saturates.
            horn_d      = ~horn_q;
            sound_cnt_d = sound_cnt_q + CW'(1);
          end
        end
      end
      ST_LOCKOUT: begin
        horn_d = 1'b0;
        if (!siren_req) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        horn_d      = 1'b0;
        sound_cnt_d = '0;
      end
    endcase
    lockout_d = (state_d == ST_LOCKOUT);
  end

  // LED blink engine. Keyed on the next siren state so the LED goes solid in
  // the same cycle the horn starts, and resumes from a fresh ON phase on exit.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_off_d   = blink_off_q;
    led_d         = led_q;
    status_prev_d = status_ind;
    if (state_d == ST_SOUND) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
      led_d       = 1'b1;
    end else if (!status_ind) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
      led_d       = 1'b0;
    end else if (!status_prev_q) begin
      // Arming edge: start the ON phase; a coincident tick is not counted.
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
      led_d       = 1'b1;
    end else begin
      if (tick) begin
        if (!blink_off_q) begin
          if (blink_cnt_q == ON_LAST) begin
            blink_off_d = 1'b1;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end else begin
          if (blink_cnt_q == OFF_LAST) begin
            blink_off_d = 1'b0;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
          end
        end
      end
      led_d = !blink_off_d;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      sound_cnt_q   <= '0;
      horn_q        <= 1'b0;
      lockout_q     <= 1'b0;
      led_q         <= 1'b0;
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
      status_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sound_cnt_q   <= sound_cnt_d;
      horn_q        <= horn_d;
      lockout_q     <= lockout_d;
      led_q         <= led_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_off_q   <= blink_off_d;
      status_prev_q <= status_prev_d;
    end
  end

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed testbench for alarm_annunciator (ON=1, OFF=3, SIREN=6, tick every 4 clocks).
module tb_alarm_annunciator;

  logic clock;
  logic reset;
  logic tick;
  logic status_ind;
  logic siren_req;
  logic led;
  logic horn;
  logic siren_lockout;

  int checks;
  int errors;

  alarm_annunciator #(
    .LED_ON_TICKS (1),
    .LED_OFF_TICKS(3),
    .SIREN_TICKS  (6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .status_ind   (status_ind),
    .siren_req    (siren_req),
    .led          (led),
    .horn         (horn),
    .siren_lockout(siren_lockout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; tick = 1'b0; status_ind = 1'b0; siren_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({led, horn, siren_lockout} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: led/horn/lockout=%b expected 000", c, {led, horn, siren_lockout});
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      checks++;
      if ({led, horn, siren_lockout} !== 3'b000) begin
        errors++;
        $display("FAIL reset_release cycle %0d: led/horn/lockout=%b expected 000", c, {led, horn, siren_lockout});
      end
    end
  endtask

  task automatic test_blink();
    int n;
    logic exp_led;
    status_ind = 1'b1;
    step();
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL blink_rise: led=%b expected 1", led);
    end
    for (int c = 0; c < 64; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      n = (c + 1) / 4;
      exp_led = ((n % 4) == 0);
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL blink_pattern cycle %0d: led=%b expected %b", c, led, exp_led);
      end
    end
    status_ind = 1'b0;
    step();
    checks++;
    if (led !== 1'b0) begin
      errors++;
      $display("FAIL blink_disarm: led=%b expected 0", led);
    end
  endtask

  task automatic test_siren_timeout();
    int n;
    logic exp_horn, exp_lock, exp_led;
    siren_req = 1'b1;
    step();
    checks++;
    if ({horn, siren_lockout, led} !== 3'b101) begin
      errors++;
      $display("FAIL timeout_entry: horn/lockout/led=%b expected 101", {horn, siren_lockout, led});
    end
    for (int c = 0; c < 40; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      n = (c + 1) / 4;
      exp_horn = (n < 6) ? ((n % 2) == 0) : 1'b0;
      exp_lock = (n >= 6);
      exp_led  = (n < 6);
      checks++;
      if ({horn, siren_lockout, led} !== {exp_horn, exp_lock, exp_led}) begin
        errors++;
        $display("FAIL timeout_seq cycle %0d: horn/lockout/led=%b expected %b",
                 c, {horn, siren_lockout, led}, {exp_horn, exp_lock, exp_led});
      end
    end
    siren_req = 1'b0;
    step();
    checks++;
    if ({horn, siren_lockout} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_release: horn/lockout=%b expected 00", {horn, siren_lockout});
    end
  endtask

  task automatic test_siren_abort();
    int n;
    logic exp_horn, exp_lock;
    siren_req = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
    end
    siren_req = 1'b0;
    step();
    checks++;
    if ({horn, siren_lockout} !== 2'b00) begin
      errors++;
      $display("FAIL abort_drop: horn/lockout=%b expected 00", {horn, siren_lockout});
    end
    for (int c = 0; c < 8; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      checks++;
      if ({horn, siren_lockout} !== 2'b00) begin
        errors++;
        $display("FAIL abort_idle cycle %0d: horn/lockout=%b expected 00", c, {horn, siren_lockout});
      end
    end
    // Retrigger with a tick in the entry cycle; it must not be counted.
    siren_req = 1'b1;
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if ({horn, siren_lockout} !== 2'b10) begin
      errors++;
      $display("FAIL abort_retrigger: horn/lockout=%b expected 10", {horn, siren_lockout});
    end
    for (int c = 0; c < 28; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      n = (c + 1) / 4;
      exp_horn = (n < 6) ? ((n % 2) == 0) : 1'b0;
      exp_lock = (n >= 6);
      checks++;
      if ({horn, siren_lockout} !== {exp_horn, exp_lock}) begin
        errors++;
        $display("FAIL abort_restart cycle %0d: horn/lockout=%b expected %b",
                 c, {horn, siren_lockout}, {exp_horn, exp_lock});
      end
    end
    siren_req = 1'b0;
    step();
    checks++;
    if (siren_lockout !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: lockout=%b expected 0", siren_lockout);
    end
  endtask

  task automatic test_siren_led();
    int n;
    logic exp_led, exp_horn;
    status_ind = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      n = (c + 1) / 4;
      exp_led = ((n % 4) == 0);
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL led_preblink cycle %0d: led=%b expected %b", c, led, exp_led);
      end
    end
    siren_req = 1'b1;
    step();
    checks++;
    if ({led, horn} !== 2'b11) begin
      errors++;
      $display("FAIL led_sound_entry: led/horn=%b expected 11", {led, horn});
    end
    for (int c = 0; c < 8; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      n = (c + 1) / 4;
      exp_horn = ((n % 2) == 0);
      checks++;
      if ({led, horn} !== {1'b1, exp_horn}) begin
        errors++;
        $display("FAIL led_sound_solid cycle %0d: led/horn=%b expected %b", c, {led, horn}, {1'b1, exp_horn});
      end
    end
    status_ind = 1'b0;
    step();
    checks++;
    if (led !== 1'b1) begin
      errors++;
      $display("FAIL led_status_drop_in_sound: led=%b expected 1", led);
    end
    status_ind = 1'b1;
    step();
    siren_req = 1'b0;
    step();
    checks++;
    if ({led, horn} !== 2'b10) begin
      errors++;
      $display("FAIL led_sound_exit: led/horn=%b expected 10", {led, horn});
    end
    for (int c = 0; c < 16; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      n = (c + 1) / 4;
      exp_led = ((n % 4) == 0);
      checks++;
      if (led !== exp_led) begin
        errors++;
        $display("FAIL led_resume cycle %0d: led=%b expected %b", c, led, exp_led);
      end
    end
    status_ind = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    logic exp_horn;
    siren_req = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({led, horn, siren_lockout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: led/horn/lockout=%b expected 000", {led, horn, siren_lockout});
    end
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if ({horn, led} !== 2'b11) begin
      errors++;
      $display("FAIL reset_restart_entry: horn/led=%b expected 11", {horn, led});
    end
    for (int c = 0; c < 20; c++) begin
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
      n = (c + 1) / 4;
      exp_horn = ((n % 2) == 0);
      checks++;
      if ({horn, siren_lockout} !== {exp_horn, 1'b0}) begin
        errors++;
        $display("FAIL reset_restart_seq cycle %0d: horn/lockout=%b expected %b",
                 c, {horn, siren_lockout}, {exp_horn, 1'b0});
      end
    end
    // Request drops on the same cycle as the final tick: IDLE, not LOCKOUT.
    step();
    step();
    step();
    tick = 1'b1;
    siren_req = 1'b0;
    step();
    tick = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({horn, siren_lockout} !== 2'b00) begin
        errors++;
        $display("FAIL final_tick_drop cycle %0d: horn/lockout=%b expected 00", c, {horn, siren_lockout});
      end
      tick = (c % 4 == 3);
      step();
      tick = 1'b0;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_blink();
    test_siren_timeout();
    test_siren_abort();
    test_siren_led();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_annunciator.md
# alarm_annunciator

Output stage of the car alarm, directly downstream of `anti_theft_fsm`. It turns the FSM's level outputs `Status_ind` and `Siren` into driven signals: a blinking armed LED, a pulsed horn with a bounded run time, and a lockout flag. The `ck` tick from `divider` paces both patterns. All outputs are registered, so the physical drivers never see combinational glitches from FSM state decode.

## Interface
- `LED_ON_TICKS`, default 1: ticks the LED stays on per blink period while armed; must be ≥1.
- `LED_OFF_TICKS`, default 3: ticks the LED stays off per blink period while armed; must be ≥1.
- `SIREN_TICKS`, default 30: number of ticks the horn sounds before lockout; must be ≥2.
- `clock` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset. `reset`=0 clears all state immediately. Release is synchronous to `clock`.
- `tick` input 1: one-`clock`-wide pacing pulse (`ck` from `divider`).
- `status_ind` input 1: armed indicator request from the FSM (level).
- `siren_req` input 1: siren request from the FSM (level).
- `led` output 1: armed LED drive.
- `horn` output 1: horn relay drive.
- `siren_lockout` output 1: high while the siren has timed out and `siren_req` is still asserted.

## Operation
- Siren FSM states:
  - IDLE: reset state.
  - SOUND: the horn is running.
  - LOCKOUT: the horn has timed out.
- Siren FSM transitions:
  - IDLE→SOUND when `siren_req`=1 is sampled. On entry, `sound_cnt`=0 and `horn`=1.
  - SOUND: on each `tick`, toggle `horn` and increment `sound_cnt`.
  - SOUND→LOCKOUT on the `tick` where `sound_cnt`==`SIREN_TICKS`-1. On this transition, `horn`←0.
  - SOUND→IDLE as soon as `siren_req`=0 is sampled. On this transition, `horn`←0.
  - LOCKOUT: `horn`=0 and `siren_lockout`=1. Exit to IDLE when `siren_req`=0 is sampled. LOCKOUT never retriggers SOUND while `siren_req` stays 1.
- `sound_cnt` is $clog2(`SIREN_TICKS`) bits wide and saturates; it never wraps inside SOUND.
- LED behaviour:
  - When `status_ind`=0 and the FSM is not in SOUND: `led`=0 and the blink counter and phase are cleared.
  - When `status_ind`=1 and the FSM is not in SOUND: the LED blinks. The ON phase lasts `LED_ON_TICKS` ticks and the OFF phase lasts `LED_OFF_TICKS` ticks. The phase counter advances only on `tick` and resets to 0 on every phase change.
  - On a 0→1 edge of `status_ind`, the LED starts in the ON phase with the counter at 0.
  - In SOUND, `led`=1 solid regardless of `status_ind`. The blink counter is held at 0 in the ON phase, so blinking resumes from a fresh ON phase when SOUND exits.
- Simultaneous events:
  - `siren_req` falls in the same cycle as the final SOUND `tick`: go to IDLE, not LOCKOUT.
  - `tick` arrives in the IDLE→SOUND entry cycle: it is not counted.
  - `status_ind` falls during SOUND: it has no effect until SOUND exits.
- Reset mid-operation (`reset`=0) immediately forces:
  - state=IDLE;
  - `led`, `horn` and `siren_lockout` to 0;
  - all counters and phase to 0.

## Timing
- Reset values: `led`=0, `horn`=0, `siren_lockout`=0, state=IDLE.
- Latency from `siren_req` rising to `horn`=1: 1 `clock`.
- Latency from `siren_req` falling to `horn`=0 and `siren_lockout`=0: 1 `clock`.
- Latency from `status_ind` rising to `led`=1: 1 `clock`.
- Horn pattern in SOUND:
  - `horn` is 1 from entry until the first tick, then alternates 0/1 per tick.
  - SOUND lasts exactly `SIREN_TICKS` ticks after entry, so the horn produces ceil(`SIREN_TICKS`/2) on-segments.
  - `siren_lockout` goes high in the same cycle that `horn` drops on timeout.
- `tick` is assumed to be at most one cycle per pulse. A `tick` held high for several cycles counts once per cycle.

## Test plan
Bench settings for all scenarios: `LED_ON_TICKS`=1, `LED_OFF_TICKS`=3, `SIREN_TICKS`=6, and `tick` every 4 `clock`s.

- Assert and release `reset` with all inputs at 0 → `led`=0, `horn`=0 and `siren_lockout`=0 throughout, and state=IDLE.
- Hold `status_ind`=1 for 16 ticks → `led` follows a repeating pattern of 1 tick high and 3 ticks low, 4 full periods, starting high 1 `clock` after the rise.
- Raise `siren_req` and hold it for 10 ticks → `horn` sequence per tick is 1,0,1,0,1,0. After the 6th tick, `horn`=0 and `siren_lockout`=1, held until `siren_req` drops, then `siren_lockout`=0 1 `clock` later.
- Raise `siren_req` and drop it after 3 ticks → `horn`=0 and state=IDLE 1 `clock` later, with no lockout. Raising `siren_req` again restarts a full 6-tick SOUND.
- Raise `siren_req` with `status_ind`=1 → `led`=1 solid during SOUND. After `siren_req` drops, `led` resumes blinking from a fresh ON phase.
- Pulse `reset` low during SOUND at tick 2 → `horn` and `led` drop to 0 asynchronously (before the next `clock` edge). After release with `siren_req`=1, SOUND restarts with `sound_cnt`=0.
